// File: rtl/clock_step_controller.sv
// Processor clock-enable controller: single-step N cycles, free run, and run-to-breakpoint.
// Breakpoint support (BP_RUN state, breakpoint register) is built only with CLOCK_STEP_BREAKPOINT_EN.
module clock_step_controller #(
  parameter int unsigned CLK_FREQ = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        cmd_ready,
  input  logic [31:0] processor_pc,
  output logic        processor_clk_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] cycles_elapsed
);
  // state  | meaning
  // IDLE   | processor halted, waiting for a command
  // STEP   | processor enabled for a fixed number of cycles
  // RUN    | processor enabled until STOP
  // BP_RUN | processor enabled until PC hits the breakpoint or STOP
  // FINISH | single cycle of done, commands refused

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_STEP   = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;
  localparam logic [1:0] OP_RUN_BP = 2'b11;

  localparam logic [31:0] unused_clk_freq = CLK_FREQ;

`ifdef CLOCK_STEP_BREAKPOINT_EN
  typedef enum logic [2:0] {S_IDLE, S_STEP, S_RUN, S_BP_RUN, S_FINISH} state_t;
  logic [31:0] breakpoint;
`else
  typedef enum logic [2:0] {S_IDLE, S_STEP, S_RUN, S_FINISH} state_t;
  logic unused_pc;
  assign unused_pc = ^processor_pc;
`endif

  state_t      state;
  logic [31:0] remaining;
  logic        accept;
  logic        stop_cmd;
  logic        term_hit;

  assign accept   = cmd_valid & cmd_ready;
  assign stop_cmd = (cmd_op == OP_STOP);

  // Natural end of an operation: last step cycle, or the PC reaching the breakpoint.
  always_comb begin
    term_hit = 1'b0;
    if (state == S_STEP) term_hit = (remaining == 32'd1);
`ifdef CLOCK_STEP_BREAKPOINT_EN
    if (state == S_BP_RUN) term_hit = processor_clk_en && (processor_pc == breakpoint);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      cmd_ready        <= 1'b1;
      processor_clk_en <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      cycles_elapsed   <= '0;
      remaining        <= '0;
`ifdef CLOCK_STEP_BREAKPOINT_EN
      breakpoint       <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (processor_clk_en && (cycles_elapsed != 32'hFFFF_FFFF))
        cycles_elapsed <= cycles_elapsed + 32'd1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_STEP: begin
                cycles_elapsed <= '0;
                if (cmd_arg == '0) begin
                  state     <= S_FINISH;
                  done      <= 1'b1;
                  cmd_ready <= 1'b0;
                end else begin
                  state            <= S_STEP;
                  remaining        <= cmd_arg;
                  processor_clk_en <= 1'b1;
                  busy             <= 1'b1;
                end
              end
              OP_RUN: begin
                cycles_elapsed   <= '0;
                state            <= S_RUN;
                processor_clk_en <= 1'b1;
                busy             <= 1'b1;
              end
              OP_RUN_BP: begin
`ifdef CLOCK_STEP_BREAKPOINT_EN
                cycles_elapsed   <= '0;
                breakpoint       <= cmd_arg;
                state            <= S_BP_RUN;
                processor_clk_en <= 1'b1;
                busy             <= 1'b1;
`else
                err <= 1'b1;
`endif
              end
              default: ;
            endcase
          end
        end
        S_FINISH: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          if (state == S_STEP) remaining <= remaining - 32'd1;
          // A new operation while one is running is refused; the running one is untouched.
          if (accept && !stop_cmd) err <= 1'b1;
          if (term_hit || (accept && stop_cmd)) begin
            state            <= S_FINISH;
            processor_clk_en <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b1;
            cmd_ready        <= 1'b0;
            remaining        <= '0;
          end
        end
      endcase
    end
  end
endmodule
